// File: rtl/pipelined_signed_mac.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_signed_mac
// Purpose  : Iterative signed multiply / multiply-accumulate. A WIDTH x WIDTH
//            signed product is built from LIMB x LIMB unsigned partial
//            products, one per clock, so a single small multiplier is used.
//            An optional accumulate mode adds into an ACC_WIDTH result with
//            optional saturation. WIDTH must be a multiple of LIMB and
//            ACC_WIDTH must be at least 2*WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_signed_mac #(
  parameter int WIDTH     = 18,
  parameter int LIMB      = 9,
  parameter int ACC_WIDTH = 2*WIDTH+4,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 acc_en,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 out_valid,
  output logic                 busy
);

  localparam int N  = WIDTH / LIMB;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             acc_q;
  logic [PW-1:0]    psum;
  logic [IW-1:0]    idx_i;
  logic [IW-1:0]    idx_j;

  logic                   last_iter;
  logic [PW-1:0]          corr_sum;
  logic [PW-1:0]          preload;
  logic [LIMB-1:0]        a_limb;
  logic [LIMB-1:0]        b_limb;
  logic [2*LIMB-1:0]      limb_prod;
  logic [PW-1:0]          partial;
  logic signed [PW-1:0]   prod_s;
  logic signed [ACC_WIDTH-1:0] base_s;
  logic signed [ACC_WIDTH:0]   sum_s;
  logic                   overflow;
  logic [ACC_WIDTH-1:0]   next_result;

  assign last_iter = (idx_i == LAST_IDX) && (idx_j == LAST_IDX);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: accept -> N*N multiply steps -> one finish cycle
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_valid)  state_next = S_MUL;
      S_MUL:   if (last_iter) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: busy covers the whole operation up to the finishing edge
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Sign correction: treating both operands as unsigned over-counts by
  // 2^WIDTH * (b<0 ? a_u : 0) + 2^WIDTH * (a<0 ? b_u : 0); preload its negation
  always_comb begin
    corr_sum = (b[WIDTH-1] ? PW'(a) : '0) + (a[WIDTH-1] ? PW'(b) : '0);
    preload  = PW'(0) - (corr_sum << WIDTH);
  end

  // One unsigned limb product per cycle, aligned to its (i+j) limb position
  always_comb begin
    a_limb    = a_q[idx_i*LIMB +: LIMB];
    b_limb    = b_q[idx_j*LIMB +: LIMB];
    limb_prod = (2*LIMB)'(a_limb) * (2*LIMB)'(b_limb);
    partial   = PW'(limb_prod) << (LIMB * (32'(idx_i) + 32'(idx_j)));
  end

  // Final sign-extend, optional accumulate at ACC_WIDTH+1 bits, clamp or wrap
  always_comb begin
    prod_s      = psum;
    base_s      = acc_q ? result : '0;
    sum_s       = (ACC_WIDTH+1)'(base_s) + (ACC_WIDTH+1)'(prod_s);
    overflow    = (sum_s[ACC_WIDTH] != sum_s[ACC_WIDTH-1]);
    next_result = sum_s[ACC_WIDTH-1:0];
    if (SATURATE && overflow) begin
      next_result = sum_s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

  // Datapath: operand capture, partial-sum iteration and result update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= 1'b0;
      psum      <= '0;
      idx_i     <= '0;
      idx_j     <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            acc_q <= acc_en;
            psum  <= preload;
            idx_i <= '0;
            idx_j <= '0;
          end
        end
        S_MUL: begin
          psum <= psum + partial;
          if (idx_j == LAST_IDX) begin
            idx_j <= '0;
            idx_i <= idx_i + ONE_IDX;
          end else begin
            idx_j <= idx_j + ONE_IDX;
          end
        end
        S_DONE: begin
          result    <= next_result;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_signed_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_signed_mac
// Purpose  : Self-checking bench. Three 18x18 instances (default, 36-bit
//            saturating, 36-bit wrapping) share one stimulus stream; a 27x27
//            instance gets random operands. Expected results are queued as
//            stimulus is driven and compared as each out_valid arrives.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_signed_mac;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, acc_en;
  logic [17:0] a, b;
  logic [39:0] result0;
  logic [35:0] result1, result2;
  logic        out_valid0, out_valid1, out_valid2;
  logic        busy0, busy1, busy2;
  logic        in_valid3, acc_en3;
  logic [26:0] a3, b3;
  logic [57:0] result3;
  logic        out_valid3, busy3;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  longint q0[$], q1[$], q2[$], q3[$];
  longint exp_acc0 = 0, exp_acc1 = 0, exp_acc2 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_signed_mac #(.WIDTH(18), .LIMB(9)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .acc_en(acc_en), .a(a), .b(b),
    .result(result0), .out_valid(out_valid0), .busy(busy0));
  pipelined_signed_mac #(.WIDTH(18), .LIMB(9), .ACC_WIDTH(36), .SATURATE(1'b1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .acc_en(acc_en), .a(a), .b(b),
    .result(result1), .out_valid(out_valid1), .busy(busy1));
  pipelined_signed_mac #(.WIDTH(18), .LIMB(9), .ACC_WIDTH(36), .SATURATE(1'b0)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .acc_en(acc_en), .a(a), .b(b),
    .result(result2), .out_valid(out_valid2), .busy(busy2));
  pipelined_signed_mac #(.WIDTH(27), .LIMB(9)) u3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .acc_en(acc_en3), .a(a3), .b(b3),
    .result(result3), .out_valid(out_valid3), .busy(busy3));

  // Reference accumulator: exact sum, then clamp or wrap to w signed bits
  function automatic longint acc_step(longint prev, longint p, logic en, int w, bit sat);
    longint s, hi, lo;
    s  = (en ? prev : 64'sd0) + p;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (sat) begin
      if (s > hi) s = hi;
      else if (s < lo) s = lo;
    end else begin
      s = s <<< (64 - w);
      s = s >>> (64 - w);
    end
    return s;
  endfunction

  task automatic push18(input logic [17:0] sa, input logic [17:0] sb, input logic sen);
    longint p;
    p = longint'($signed(sa)) * longint'($signed(sb));
    exp_acc0 = acc_step(exp_acc0, p, sen, 40, 1'b1);
    exp_acc1 = acc_step(exp_acc1, p, sen, 36, 1'b1);
    exp_acc2 = acc_step(exp_acc2, p, sen, 36, 1'b0);
    q0.push_back(exp_acc0);
    q1.push_back(exp_acc1);
    q2.push_back(exp_acc2);
  endtask

  // Scoreboards: every out_valid pops and compares one expected value
  always @(negedge clk) begin : mon0
    longint e;
    if (out_valid0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++; $display("FAIL sb0 unexpected out_valid, result=%0d", $signed(result0));
      end else begin
        e = q0.pop_front();
        if (longint'($signed(result0)) !== e) begin
          errors++; $display("FAIL sb0 result got=%0d exp=%0d", $signed(result0), e);
        end
      end
    end
  end
  always @(negedge clk) begin : mon1
    longint e;
    if (out_valid1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++; $display("FAIL sb1 unexpected out_valid, result=%0d", $signed(result1));
      end else begin
        e = q1.pop_front();
        if (longint'($signed(result1)) !== e) begin
          errors++; $display("FAIL sb1 result got=%0d exp=%0d", $signed(result1), e);
        end
      end
    end
  end
  always @(negedge clk) begin : mon2
    longint e;
    if (out_valid2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++; $display("FAIL sb2 unexpected out_valid, result=%0d", $signed(result2));
      end else begin
        e = q2.pop_front();
        if (longint'($signed(result2)) !== e) begin
          errors++; $display("FAIL sb2 result got=%0d exp=%0d", $signed(result2), e);
        end
      end
    end
  end
  always @(negedge clk) begin : mon3
    longint e;
    if (out_valid3) begin
      checks++;
      if (q3.size() == 0) begin
        errors++; $display("FAIL sb3 unexpected out_valid, result=%0d", $signed(result3));
      end else begin
        e = q3.pop_front();
        if (longint'($signed(result3)) !== e) begin
          errors++; $display("FAIL sb3 result got=%0d exp=%0d a=%0d b=%0d", $signed(result3), e,
                             $signed(a3), $signed(b3));
        end
      end
    end
  end

  // Drive one 18-bit op; returns latency (-1 on timeout) and busy-cycle count
  task automatic do_op(input logic [17:0] sa, input logic [17:0] sb, input logic sen,
                       output int lat, output int bc);
    int start;
    @(negedge clk);
    a = sa; b = sb; acc_en = sen; in_valid = 1'b1;
    push18(sa, sb, sen);
    @(negedge clk);
    start = cyc; in_valid = 1'b0;
    lat = -1; bc = 0;
    for (int k = 0; k < 30; k++) begin
      if (out_valid0) begin lat = cyc - start; break; end
      if (busy0) bc++;
      @(negedge clk);
    end
  endtask

  task automatic do_op27(input logic [26:0] sa, input logic [26:0] sb, output int lat);
    int start;
    @(negedge clk);
    a3 = sa; b3 = sb; in_valid3 = 1'b1;
    q3.push_back(longint'($signed(sa)) * longint'($signed(sb)));
    @(negedge clk);
    start = cyc; in_valid3 = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (out_valid3) begin lat = cyc - start; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; acc_en = 1'b0; a = '0; b = '0;
    in_valid3 = 1'b0; acc_en3 = 1'b0; a3 = '0; b3 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (result0 !== '0 || out_valid0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL reset u0 result=%0d out_valid=%b busy=%b", result0, out_valid0, busy0);
    end
    checks++;
    if (result3 !== '0 || out_valid3 !== 1'b0 || busy3 !== 1'b0) begin
      errors++; $display("FAIL reset u3 result=%0d out_valid=%b busy=%b", result3, out_valid3, busy3);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int lat, bc;
    do_op(18'(3), 18'(-5), 1'b0, lat, bc);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL basic latency got=%0d exp=5", lat); end
    checks++;
    if (bc !== 5) begin errors++; $display("FAIL basic busy cycles got=%0d exp=5", bc); end
    checks++;
    if (longint'($signed(result0)) !== -64'sd15) begin
      errors++; $display("FAIL basic result got=%0d exp=-15", $signed(result0));
    end
    @(negedge clk);
    checks++;
    if (out_valid0 !== 1'b0) begin errors++; $display("FAIL basic out_valid width got=%b exp=0", out_valid0); end
  endtask

  task automatic test_extremes;
    int lat, bc;
    do_op(18'(-131072), 18'(-131072), 1'b0, lat, bc);
    checks++;
    if (longint'($signed(result0)) !== 64'sd17179869184) begin
      errors++; $display("FAIL min_sq result got=%0d exp=17179869184", $signed(result0));
    end
    do_op(18'(-131072), 18'(131071), 1'b0, lat, bc);
    checks++;
    if (longint'($signed(result0)) !== -64'sd17179738112) begin
      errors++; $display("FAIL min_max result got=%0d exp=-17179738112", $signed(result0));
    end
  endtask

  task automatic test_accumulate;
    int lat, bc;
    logic [17:0] ta[4] = '{18'(2), 18'(4), 18'(-1), 18'(1)};
    logic [17:0] tb_[4] = '{18'(3), 18'(5), 18'(7), 18'(1)};
    logic        te[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    longint      tr[4] = '{64'sd6, 64'sd26, 64'sd19, 64'sd1};
    for (int k = 0; k < 4; k++) begin
      do_op(ta[k], tb_[k], te[k], lat, bc);
      checks++;
      if (longint'($signed(result0)) !== tr[k]) begin
        errors++; $display("FAIL accumulate step %0d got=%0d exp=%0d", k, $signed(result0), tr[k]);
      end
    end
  endtask

  task automatic test_saturate;
    int lat, bc;
    do_op(18'(-131072), 18'(-131072), 1'b0, lat, bc);
    do_op(18'(-131072), 18'(-131072), 1'b1, lat, bc);
    checks++;
    if (longint'($signed(result1)) !== 64'sd34359738367) begin
      errors++; $display("FAIL sat_pos got=%0d exp=34359738367", $signed(result1));
    end
    checks++;
    if (longint'($signed(result2)) !== -64'sd34359738368) begin
      errors++; $display("FAIL wrap_pos got=%0d exp=-34359738368", $signed(result2));
    end
    do_op(18'(-131072), 18'(131071), 1'b0, lat, bc);
    do_op(18'(-131072), 18'(131071), 1'b1, lat, bc);
    do_op(18'(-131072), 18'(131071), 1'b1, lat, bc);
    checks++;
    if (longint'($signed(result1)) !== -64'sd34359738368) begin
      errors++; $display("FAIL sat_neg got=%0d exp=-34359738368", $signed(result1));
    end
  endtask

  task automatic test_ignore_busy;
    int lat, start, pulses;
    @(negedge clk);
    a = 18'(3); b = 18'(-5); acc_en = 1'b0; in_valid = 1'b1;
    push18(18'(3), 18'(-5), 1'b0);
    @(negedge clk);
    start = cyc; in_valid = 1'b0;
    @(negedge clk);
    a = 18'(100); b = 18'(100); acc_en = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 30; k++) begin
      if (out_valid0) begin lat = cyc - start; break; end
      @(negedge clk);
    end
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL ignore latency got=%0d exp=5", lat); end
    checks++;
    if (longint'($signed(result0)) !== -64'sd15) begin
      errors++; $display("FAIL ignore result got=%0d exp=-15", $signed(result0));
    end
    pulses = 0;
    repeat (10) begin @(negedge clk); if (out_valid0) pulses++; end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL ignore extra pulses got=%0d exp=0", pulses); end
  endtask

  task automatic test_back_to_back;
    int start, t1, t2;
    logic busy_after;
    @(negedge clk);
    a = 18'(2); b = 18'(3); acc_en = 1'b0; in_valid = 1'b1;
    push18(18'(2), 18'(3), 1'b0);
    @(negedge clk);
    start = cyc;
    a = 18'(-4); b = 18'(6); acc_en = 1'b1;
    push18(18'(-4), 18'(6), 1'b1);
    t1 = -1; t2 = -1; busy_after = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (t1 >= 0 && cyc == t1 + 1) begin busy_after = busy0; in_valid = 1'b0; end
      if (out_valid0) begin
        if (t1 < 0) begin
          t1 = cyc;
          checks++;
          if (longint'($signed(result0)) !== 64'sd6) begin
            errors++; $display("FAIL b2b first got=%0d exp=6", $signed(result0));
          end
        end else begin
          t2 = cyc;
          checks++;
          if (longint'($signed(result0)) !== -64'sd18) begin
            errors++; $display("FAIL b2b second got=%0d exp=-18", $signed(result0));
          end
          break;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (t1 - start !== 5) begin errors++; $display("FAIL b2b first latency got=%0d exp=5", t1 - start); end
    checks++;
    if (t2 - t1 !== 6) begin errors++; $display("FAIL b2b spacing got=%0d exp=6", t2 - t1); end
    checks++;
    if (busy_after !== 1'b1) begin errors++; $display("FAIL b2b reaccept busy got=%b exp=1", busy_after); end
  endtask

  task automatic test_reset_mid;
    int lat, bc, pulses;
    @(negedge clk);
    a = 18'(7); b = 18'(9); acc_en = 1'b1; in_valid = 1'b1;
    push18(18'(7), 18'(9), 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    q0.delete(); q1.delete(); q2.delete();
    exp_acc0 = 0; exp_acc1 = 0; exp_acc2 = 0;
    #1;
    checks++;
    if (busy0 !== 1'b0 || out_valid0 !== 1'b0) begin
      errors++; $display("FAIL reset_mid busy=%b out_valid=%b exp 0/0", busy0, out_valid0);
    end
    checks++;
    if (result0 !== '0 || result1 !== '0) begin
      errors++; $display("FAIL reset_mid result got=%0d/%0d exp=0", result0, result1);
    end
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (10) begin @(negedge clk); if (out_valid0) pulses++; end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL reset_mid pulses got=%0d exp=0", pulses); end
    do_op(18'(1), 18'(1), 1'b1, lat, bc);
    checks++;
    if (lat !== 5 || longint'($signed(result0)) !== 64'sd1) begin
      errors++; $display("FAIL reset_mid resume lat=%0d result=%0d exp 5/1", lat, $signed(result0));
    end
  endtask

  task automatic test_random27;
    int lat, bad;
    logic [26:0] ra, rb;
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      case (k)
        0:       begin ra = 27'h4000000; rb = 27'h4000000; end
        1:       begin ra = 27'h4000000; rb = 27'h3ffffff; end
        2:       begin ra = 27'h7ffffff; rb = 27'h3ffffff; end
        default: begin ra = 27'($urandom); rb = 27'($urandom); end
      endcase
      do_op27(ra, rb, lat);
      checks++;
      if (lat !== 10) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand27 latency got=%0d exp=10 (op %0d)", lat, k);
      end
    end
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_basic;
    test_extremes;
    test_accumulate;
    test_saturate;
    test_ignore_busy;
    test_back_to_back;
    test_reset_mid;
    test_random27;
    repeat (3) @(negedge clk);
    checks++;
    if (q0.size() + q1.size() + q2.size() + q3.size() !== 0) begin
      errors++; $display("FAIL scoreboard leftover got=%0d exp=0", q0.size() + q1.size() + q2.size() + q3.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
